// File: rtl/demux_1t2_64_buf.sv
// demux_1t2_64_buf: routes a 64-bit input stream to one of two output ports.
// Each port has its own 2-entry FIFO with a registered head word and a
// free-running count of accepted words. sel=1 selects port A, sel=0 port B.
module demux_1t2_64_buf #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [63:0]      din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [63:0]      b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]       occ  [2];
  logic [63:0]      head [2];
  logic [63:0]      tail [2];
  logic [CNT_W-1:0] cnt  [2];
  logic [1:0]       room;
  logic [1:0]       push;
  logic [1:0]       pop;

  // Acceptance depends only on the select and occupancy, never on consumer ready.
  always_comb begin
    room[0]  = (occ[0] != 2'd2);
    room[1]  = (occ[1] != 2'd2);
    in_ready = sel ? room[0] : room[1];
    push[0]  = in_valid &&  sel && room[0];
    push[1]  = in_valid && !sel && room[1];
    pop[0]   = (occ[0] != 2'd0) && a_ready;
    pop[1]   = (occ[1] != 2'd0) && b_ready;
  end

  // Per-port FIFO update; the second entry is never visible, so it is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        occ[i]  <= '0;
        head[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10: begin
            if (occ[i] == 2'd0) begin
              head[i] <= din;
            end else begin
              tail[i] <= din;
            end
            occ[i] <= occ[i] + 2'd1;
          end
          2'b01: begin
            if (occ[i] == 2'd2) begin
              head[i] <= tail[i];
            end
            occ[i] <= occ[i] - 2'd1;
          end
          // Push and pop together only happen at occupancy 1: new word replaces head.
          2'b11: begin
            head[i] <= din;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = (occ[0] != 2'd0);
  assign b_valid = (occ[1] != 2'd0);
  assign a_cnt   = cnt[0];
  assign b_cnt   = cnt[1];

endmodule

// File: tb/tb_demux_1t2_64_buf.sv
// Scoreboard bench for demux_1t2_64_buf: stimulus pushes expected words per
// port into queues; a negedge monitor pops and compares on each handshake.
module tb_demux_1t2_64_buf;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic [63:0]   din;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   a_data;
  logic          a_valid;
  logic          a_ready;
  logic [63:0]   b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int checks = 0;
  int errors = 0;

  demux_1t2_64_buf #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Handshakes complete at the next rising edge; inputs are stable from here on.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        check("a_expected_word_present", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) check("a_data_order", a_data, qa.pop_front());
      end
      if (b_valid && b_ready) begin
        check("b_expected_word_present", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) check("b_data_order", b_data, qb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word; exp_rdy is the hand-derived acceptance for this cycle.
  task automatic offer(input logic s, input logic [63:0] d, input logic exp_rdy);
    sel = s;
    din = d;
    in_valid = 1'b1;
    #1;
    check(s ? "in_ready_a" : "in_ready_b", 64'(in_ready), 64'(exp_rdy));
    if (exp_rdy) begin
      if (s) qa.push_back(d);
      else   qb.push_back(d);
    end
  endtask

  task automatic check_ready_both();
    sel = 1'b1; #1; check("in_ready_sel1_idle", 64'(in_ready), 64'd1);
    sel = 1'b0; #1; check("in_ready_sel0_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    rst = 1'b1; sel = 1'b0; din = '0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

    // Reset state
    repeat (2) step();
    rst = 1'b0;
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_a_data", a_data, 64'h0);
    check("rst_b_data", b_data, 64'h0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_b_cnt", 64'(b_cnt), 64'd0);
    check_ready_both();

    // Route to A
    offer(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
    step();
    in_valid = 1'b0;
    check("route_a_valid", 64'(a_valid), 64'd1);
    check("route_a_data", a_data, 64'hDEAD_BEEF_0000_0001);
    check("route_b_valid", 64'(b_valid), 64'd0);
    check("route_a_cnt", 64'(a_cnt), 64'd1);
    check("route_b_cnt", 64'(b_cnt), 64'd0);

    // Drain, then backpressure on A
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check("drain_a_valid", 64'(a_valid), 64'd0);
    offer(1'b1, 64'h0000_0000_0000_0011, 1'b1);
    step();
    offer(1'b1, 64'h0000_0000_0000_0022, 1'b1);
    step();
    offer(1'b1, 64'h0000_0000_0000_0033, 1'b0);
    sel = 1'b0;
    #1;
    check("bp_in_ready_other_port", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    sel = 1'b1;
    check("bp_a_data_head", a_data, 64'h0000_0000_0000_0011);
    check("bp_a_cnt", 64'(a_cnt), 64'd3);
    step();
    step();
    check("bp_a_data_stable", a_data, 64'h0000_0000_0000_0011);
    a_ready = 1'b1;
    step();
    check("bp_a_data_second", a_data, 64'h0000_0000_0000_0022);
    step();
    a_ready = 1'b0;
    check("bp_a_drained", 64'(a_valid), 64'd0);

    // Same-cycle push and pop on A at occupancy 2 and 1
    offer(1'b1, 64'h0000_0000_0000_0044, 1'b1);
    step();
    offer(1'b1, 64'h0000_0000_0000_0055, 1'b1);
    step();
    a_ready = 1'b1;
    offer(1'b1, 64'h0000_0000_0000_0066, 1'b0);
    step();
    check("full_pop_head_advance", a_data, 64'h0000_0000_0000_0055);
    offer(1'b1, 64'h0000_0000_0000_0066, 1'b1);
    step();
    check("occ1_pushpop_valid", 64'(a_valid), 64'd1);
    check("occ1_pushpop_head", a_data, 64'h0000_0000_0000_0066);
    // Pop A while pushing B
    offer(1'b0, 64'h0000_0000_0000_0077, 1'b1);
    step();
    in_valid = 1'b0;
    a_ready = 1'b0;
    check("cross_a_valid", 64'(a_valid), 64'd0);
    check("cross_b_valid", 64'(b_valid), 64'd1);
    check("cross_b_data", b_data, 64'h0000_0000_0000_0077);
    check("cross_a_cnt", 64'(a_cnt), 64'd6);
    check("cross_b_cnt", 64'(b_cnt), 64'd1);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("cross_b_drained", 64'(b_valid), 64'd0);

    // in_valid low never changes state
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      din = 64'hFFFF_0000_0000_0000 | 64'(i);
      step();
    end
    check("idle_a_cnt", 64'(a_cnt), 64'd6);
    check("idle_b_cnt", 64'(b_cnt), 64'd1);
    check("idle_a_valid", 64'(a_valid), 64'd0);
    check("idle_b_valid", 64'(b_valid), 64'd0);

    // Reset mid-operation with a concurrent push and pop
    offer(1'b1, 64'h0000_0000_0000_0088, 1'b1);
    step();
    offer(1'b1, 64'h0000_0000_0000_0099, 1'b1);
    step();
    offer(1'b0, 64'h0000_0000_0000_00AA, 1'b1);
    step();
    in_valid = 1'b0;
    sel = 1'b1;
    #1;
    check("pre_rst_a_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    sel = 1'b0;
    din = 64'h0000_0000_0000_00BB;
    a_ready = 1'b1;
    qa.delete();
    qb.delete();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    a_ready = 1'b0;
    check("mid_rst_a_valid", 64'(a_valid), 64'd0);
    check("mid_rst_b_valid", 64'(b_valid), 64'd0);
    check("mid_rst_a_data", a_data, 64'h0);
    check("mid_rst_b_data", b_data, 64'h0);
    check("mid_rst_a_cnt", 64'(a_cnt), 64'd0);
    check("mid_rst_b_cnt", 64'(b_cnt), 64'd0);
    check_ready_both();

    // Streaming 100 words alternating ports, consumers always ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = {16'h5EED, 48'(i)};
      offer((i % 2) == 0, w, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("stream_a_cnt", 64'(a_cnt), 64'd50);
    check("stream_b_cnt", 64'(b_cnt), 64'd50);
    check("stream_qa_empty", 64'(qa.size()), 64'd0);
    check("stream_qb_empty", 64'(qb.size()), 64'd0);

    // Counter wrap on B after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = {16'hB0B0, 48'(i)};
      offer(1'b0, w, 1'b1);
      if (i == 255) check("wrap_b_cnt_max", 64'(b_cnt), 64'hFF);
      step();
    end
    in_valid = 1'b0;
    check("wrap_b_cnt_zero", 64'(b_cnt), 64'd0);
    offer(1'b0, 64'h0000_0000_C0DE_0001, 1'b1);
    step();
    in_valid = 1'b0;
    check("wrap_b_cnt_one", 64'(b_cnt), 64'd1);
    check("wrap_a_cnt", 64'(a_cnt), 64'd0);

    // Final drain, bounded
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
    check("final_qa_empty", 64'(qa.size()), 64'd0);
    check("final_qb_empty", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1t2_64_buf.md
DEMUX_1T2_64_BUF -- requirements
Module: demux_1t2_64_buf

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-port accepted-word counters.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sel  input  1  route select: 1 routes to port A, 0 routes to port B (same polarity as MUX2T1-style selects).
REQ-005 din  input  64  input word.
REQ-006 in_valid  input  1  din/sel valid.
REQ-007 in_ready  output  1  block can accept the word toward the currently selected port.
REQ-008 a_data  output  64  port A head word.
REQ-009 a_valid  output  1  port A holds at least one word.
REQ-010 a_ready  input  1  port A consumer accepts.
REQ-011 b_data  output  64  port B head word.
REQ-012 b_valid  output  1  port B holds at least one word.
REQ-013 b_ready  input  1  port B consumer accepts.
REQ-014 a_cnt  output  CNT_W  words accepted into port A since reset.
REQ-015 b_cnt  output  CNT_W  words accepted into port B since reset.

Function
REQ-016 Each port SHALL own an independent 2-entry FIFO (occupancy 0, 1 or 2) with registered head output.
REQ-017 in_ready SHALL equal (sel ? occA!=2 : occB!=2), combinational from sel and occupancy only; no path from a_ready/b_ready to in_ready.
REQ-018 Push: in_valid & in_ready at a rising edge SHALL write din into the selected port FIFO; the other port is untouched.
REQ-019 Latency: a word pushed into an empty port SHALL appear on x_data with x_valid=1 on the cycle after the push edge.
REQ-020 Pop: x_valid & x_ready at a rising edge SHALL remove the head; the second entry, if any, becomes head on the next cycle.
REQ-021 x_valid SHALL equal (occX!=0); x_data SHALL be stable while x_valid=1 and x_ready=0.
REQ-022 Simultaneous push and pop on the same port: occupancy unchanged; order preserved; with occ=1 the pushed word becomes head next cycle.
REQ-023 Full port (occ=2): in_ready=0 for that select even if x_ready=1 in the same cycle; push not taken.
REQ-024 Pop on empty port (x_ready=1, x_valid=0) SHALL have no effect.
REQ-025 A push to one port and a pop from the other in the same cycle SHALL both complete.
REQ-026 Per-port order SHALL be strict FIFO; no reordering, duplication or loss.
REQ-027 x_cnt SHALL increment by 1 on each push into port X, wrapping from 2^CNT_W-1 to 0.
REQ-028 in_valid=0 SHALL never change any state, regardless of sel or din.
REQ-029 x_ready with x_valid=0 and in_valid with in_ready=0 SHALL both be legal and ignored.

Reset
REQ-030 rst=1 at a rising edge SHALL set occA=occB=0, a_valid=b_valid=0, a_data=b_data=64'h0, a_cnt=b_cnt=0.
REQ-031 Reset SHALL take priority over simultaneous push/pop; buffered words SHALL be discarded.
REQ-032 in_ready SHALL read 1 for either sel on the first cycle after reset deasserts.
REQ-033 FIFO storage not visible on outputs need not be cleared.

Verification
REQ-034 Route: sel=1, din=64'hDEAD_BEEF_0000_0001, in_valid 1 cycle, a_ready=0 -> next cycle a_valid=1, a_data=that word, b_valid=0, a_cnt=1, b_cnt=0.
REQ-035 Backpressure: a_ready=0, push 3 words to A back-to-back -> first two accepted, in_ready=0 on 3rd with sel=1, in_ready=1 with sel=0; release a_ready -> words out in order 1,2.
REQ-036 Streaming: a_ready=1 continuously, push 100 words alternating sel -> A and B receive 50 each in order, a_cnt=b_cnt=50, no stall once both ports drain.
REQ-037 Same-cycle push+pop on A with occA=2 -> push refused, head advances; with occA=1 -> push taken, occupancy stays 1.
REQ-038 Reset mid-operation: occA=2, occB=1, rst=1 one cycle -> all valids 0, data 0, counts 0, in_ready=1.
REQ-039 Counter wrap: force 2^CNT_W pushes to B -> b_cnt returns to 0, data integrity unaffected.
